// File: rtl/player_input_ctrl.sv
// player_input_ctrl: conditions four raw direction buttons into a priority-resolved
// held direction and a rate-limited one-hot move strobe (one strobe = one step).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset, clears every flop
//   btn_up     raw asynchronous button, active-high
//   btn_down   raw asynchronous button, active-high
//   btn_left   raw asynchronous button, active-high
//   btn_right  raw asynchronous button, active-high
//   held_dir   debounced level, one-hot {up,down,left,right} or zero
//   move_dir   single-cycle move strobe, same encoding, zero when idle
module player_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned MOVE_PERIOD     = 1666666
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [3:0] held_dir,
  output logic [3:0] move_dir
);

  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned PerW = $clog2(MOVE_PERIOD) + 1;
  localparam logic [DbW-1:0]  DbMax  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PerW-1:0] PerMax = PerW'(MOVE_PERIOD - 1);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  // Bit order everywhere: [3] up, [2] down, [1] left, [0] right.
  logic [3:0] btn_raw;
  assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      stable_q, stable_d;
  logic [DbW-1:0]  db_cnt_q [4];
  logic [DbW-1:0]  db_cnt_d [4];
  logic [3:0]      held_q, held_d;
  logic [3:0]      move_q, move_d;
  logic [3:0]      last_q, last_d;
  logic [PerW-1:0] per_cnt_q, per_cnt_d;
  state_e          state_q, state_d;

  // Debounce: a change is accepted only after DEBOUNCE_CYCLES consecutive mismatches;
  // any return to the stable value clears the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DbMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Fixed priority up > down > left > right keeps the level one-hot.
  always_comb begin
    held_d = 4'b0000;
    if (stable_q[3]) begin
      held_d = 4'b1000;
    end else if (stable_q[2]) begin
      held_d = 4'b0100;
    end else if (stable_q[1]) begin
      held_d = 4'b0010;
    end else if (stable_q[0]) begin
      held_d = 4'b0001;
    end
  end

  // Rate limiter. A direction change takes precedence over the terminal count so a
  // coincident change yields exactly one strobe and a restarted period.
  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    move_d    = 4'b0000;
    last_d    = last_q;
    case (state_q)
      StIdle: begin
        per_cnt_d = '0;
        if (held_q != 4'b0000) begin
          move_d  = held_q;
          last_d  = held_q;
          state_d = StHold;
        end
      end
      StHold: begin
        if (held_q == 4'b0000) begin
          state_d   = StIdle;
          per_cnt_d = '0;
        end else if (held_q != last_q) begin
          move_d    = held_q;
          last_d    = held_q;
          per_cnt_d = '0;
        end else if (per_cnt_q == PerMax) begin
          move_d    = held_q;
          per_cnt_d = '0;
        end else begin
          per_cnt_d = per_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = StIdle;
        per_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
      end
      held_q    <= '0;
      move_q    <= '0;
      last_q    <= '0;
      per_cnt_q <= '0;
      state_q   <= StIdle;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      held_q    <= held_d;
      move_q    <= move_d;
      last_q    <= last_d;
      per_cnt_q <= per_cnt_d;
      state_q   <= state_d;
    end
  end

  assign held_dir = held_q;
  assign move_dir = move_q;

endmodule

// File: doc/player_input_ctrl.md
# player_input_ctrl

Conditions the four raw direction push-buttons and produces the one-hot direction strobe consumed by the player movement stage. It synchronizes and debounces each button, resolves simultaneous presses by fixed priority, and rate-limits movement so that each strobe requests exactly one 2-pixel step. Its move_dir output drives the movement stage's 4-bit direction input directly, and that stage runs on the same clk.

## Interface
- DEBOUNCE_CYCLES, 500000 — consecutive stable cycles required to accept a button change; minimum 1.
- MOVE_PERIOD, 1666666 — cycles between repeat strobes while a direction is held; minimum 2.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- btn_up  input  1  raw asynchronous button, active-high.
- btn_down  input  1  raw asynchronous button, active-high.
- btn_left  input  1  raw asynchronous button, active-high.
- btn_right  input  1  raw asynchronous button, active-high.
- held_dir  output  4  debounced, priority-resolved level: 1000 up, 0100 down, 0010 left, 0001 right, 0000 none.
- move_dir  output  4  single-cycle move strobe, same encoding; 0000 when idle.

## Operation
- Synchronizer: two flops per button, reset to 0.
- Debounce, per button:
  - Keep a stable bit and a counter of width $clog2(DEBOUNCE_CYCLES)+1.
  - If the synced value equals stable, clear the counter.
  - Otherwise increment the counter. When the counter equals DEBOUNCE_CYCLES-1 while still mismatched, load stable with the synced value and clear the counter.
  - Any bounce back to the stable value restarts the count.
- Priority: up > down > left > right. The highest-priority stable button wins, so opposite directions never both appear. held_dir is registered from the stable bits and is always one-hot or zero.
- Rate FSM, with a period counter of width $clog2(MOVE_PERIOD)+1:
  - IDLE: move_dir = 0, period counter held at 0. If held_dir ≠ 0, pulse move_dir = held_dir and go to HOLD with the counter at 0.
  - HOLD, held_dir = 0: go to IDLE, no pulse, counter cleared.
  - HOLD, held_dir nonzero and different from the last pulsed direction: pulse immediately with the new direction and restart the counter at 0.
  - HOLD, same direction: increment the counter. At MOVE_PERIOD-1, pulse move_dir = held_dir and clear the counter.
- move_dir is registered. It is nonzero for exactly one cycle per pulse and zero otherwise.
- Reset (rst_n = 0 at an edge): every flop clears, including synchronizers, stable bits, counters, held_dir, move_dir and last direction, and the FSM goes to IDLE. This applies mid-debounce and mid-HOLD. After reset a held button is re-debounced from scratch.

## Timing
- Number edges from E0, the first edge that samples a clean press.
- The synced value is valid after E1. stable updates at E(DEBOUNCE_CYCLES+1).
- held_dir updates at E(DEBOUNCE_CYCLES+2). The first move_dir pulse is at E(DEBOUNCE_CYCLES+3).
- While the same direction is held, pulses are spaced exactly MOVE_PERIOD cycles apart.
- Release: held_dir clears DEBOUNCE_CYCLES+2 edges after the first clean low sample. No pulse is issued on release.
- A direction change within HOLD pulses one cycle after held_dir changes, independent of the period counter.
- Simultaneous change of held_dir and counter terminal count: the direction-change rule applies, giving one pulse and a counter restart, never two pulses.
- Reset values: held_dir = 0000, move_dir = 0000.

## Test plan
- All tests use DEBOUNCE_CYCLES=4 and MOVE_PERIOD=10.
- Clean press: btn_right rises before E0 and stays high.
  - held_dir = 0001 at E6.
  - move_dir = 0001 for one cycle at E7, then again at E17 and E27.
  - move_dir = 0000 on all other cycles.
- Bounce: btn_up toggles every 2 cycles for 20 cycles, then holds high.
  - No pulse during the bounce.
  - First pulse of 1000 arrives 7 edges after the last transition.
- Priority and direction change: hold left, then also press up.
  - Pulses of 0010 until up is debounced.
  - Then 1000 one cycle after held_dir becomes 1000, with the period restarted from that pulse.
- Release: hold down for 3 pulses, then release.
  - held_dir = 0000 six edges after release.
  - No further pulse; FSM returns to IDLE.
  - A re-press gives an immediate first pulse after debounce.
- Reset mid-HOLD: assert rst_n = 0 for one edge between pulses while btn_left is held.
  - All outputs are 0000 the next cycle.
  - The next pulse appears at DEBOUNCE_CYCLES+3 = 7 edges after rst_n returns high.
